// File: rtl/shape_pkg.sv
// Shared types and defaults for the shape-area scheduler slice.
package shape_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 16;

  typedef enum logic [1:0] {
    RECT     = 2'b00,
    SQUARE   = 2'b01,
    TRIANGLE = 2'b10,
    ILLEGAL  = 2'b11
  } shape_type_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } sched_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/shape_area_sched_if.sv
// Request/response bundle between shape requesters, the scheduler and the result consumer.
interface shape_area_sched_if
  import shape_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [2*N_REQ-1:0] req_type;
  logic [W*N_REQ-1:0] req_w;
  logic [W*N_REQ-1:0] req_h;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [2*W-1:0]     rsp_area;
  logic               rsp_err;

  modport master (
    output req_valid, req_type, req_w, req_h, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_area, rsp_err
  );

  modport slave (
    input  req_valid, req_type, req_w, req_h, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_area, rsp_err
  );

endinterface

// File: rtl/shape_mul_seq.sv
// Iterative unsigned shift-add multiplier, LSB first; start performs the first step,
// done pulses for one cycle once all W steps are in and p holds the product.
module shape_mul_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc  <= b[0] ? {{W{1'b0}}, a} : '0;
        a_sh <= {{W{1'b0}}, a} << 1;
        b_sh <= b >> 1;
        cnt  <= CW'(W - 1);
        busy <= (W > 1);
        done <= (W == 1);
      end else if (busy) begin
        if (b_sh[0]) acc <= acc + a_sh;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt - 1'b1;
        // down-counter terminal count: this is the last partial product
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign p = acc;

endmodule

// File: rtl/shape_area_sched.sv
// Round-robin scheduler sharing one shift-add multiplier among N_REQ shape-area requesters.
// Optional completion counters are built when SHAPE_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | arbitrate; combinational req_ready to the round-robin winner
//   MUL   | multiplier running W shift-add steps
//   RESP  | result held on rsp_* until rsp_ready
module shape_area_sched
  import shape_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  shape_area_sched_if.slave bus
`ifdef SHAPE_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_rect,
  output logic [15:0]       stat_sqr,
  output logic [15:0]       stat_tri,
  output logic [15:0]       stat_err
`endif
);

  sched_state_t   state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  shape_type_t     typ_q;
  shape_type_t     sel_type;
  logic [W-1:0]    sel_w;
  logic [W-1:0]    sel_h;
  logic            accept;
  logic [N_REQ-1:0] ready;

  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [2*W-1:0]  rsp_area_q;
  logic            rsp_err_q;

  logic            mul_start;
  logic [W-1:0]    mul_b;
  logic            mul_busy;
  logic            mul_done;
  logic [2*W-1:0]  mul_p;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign sel_type = shape_type_t'(bus.req_type[int'(win_id)*2 +: 2]);
  assign sel_w    = bus.req_w[int'(win_id)*W +: W];
  assign sel_h    = bus.req_h[int'(win_id)*W +: W];
  assign accept   = (state == IDLE) && win_found;

  always_comb begin
    ready = '0;
    if (accept) ready[win_id] = 1'b1;
  end

  assign mul_start = accept && (sel_type != ILLEGAL) && !mul_busy;
  assign mul_b     = (sel_type == SQUARE) ? sel_w : sel_h;

  shape_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (sel_w),
    .b     (mul_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      typ_q       <= RECT;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_area_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr   <= (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
            rsp_id_q <= win_id;
            typ_q    <= sel_type;
            if (sel_type == ILLEGAL) begin
              rsp_area_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              rsp_err_q <= 1'b0;
              state     <= MUL;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            rsp_area_q  <= (typ_q == TRIANGLE) ? (mul_p >> 1) : mul_p;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_area  = rsp_area_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef SHAPE_STATS_EN
  logic rsp_hs;
  assign rsp_hs = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rect <= '0;
      stat_sqr  <= '0;
      stat_tri  <= '0;
      stat_err  <= '0;
    end else if (stat_clr) begin
      stat_rect <= '0;
      stat_sqr  <= '0;
      stat_tri  <= '0;
      stat_err  <= '0;
    end else if (rsp_hs) begin
      case (typ_q)
        RECT:     stat_rect <= sat_inc16(stat_rect);
        SQUARE:   stat_sqr  <= sat_inc16(stat_sqr);
        TRIANGLE: stat_tri  <= sat_inc16(stat_tri);
        default:  stat_err  <= sat_inc16(stat_err);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_shape_area_sched.sv
// Directed bench for shape_area_sched: vector table plus arbitration, back-pressure and reset sequences.
module tb_shape_area_sched;
  import shape_pkg::*;

  localparam int N  = 4;
  localparam int WW = 16;

  typedef struct {
    int          req;
    logic [1:0]  typ;
    logic [15:0] w;
    logic [15:0] h;
    logic [31:0] area;
    logic        err;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shape_area_sched_if #(.N_REQ(N), .W(WW), .ID_W(2)) bus ();

`ifdef SHAPE_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_rect, stat_sqr, stat_tri, stat_err;
`endif

  shape_area_sched #(.N_REQ(N), .W(WW), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SHAPE_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_rect (stat_rect),
    .stat_sqr  (stat_sqr),
    .stat_tri  (stat_tri),
    .stat_err  (stat_err)
`endif
  );

  int total = 0;
  int bad   = 0;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] t, input logic [15:0] w, input logic [15:0] h);
    bus.req_type[r*2 +: 2] = t;
    bus.req_w[r*WW +: WW]  = w;
    bus.req_h[r*WW +: WW]  = h;
    bus.req_valid[r]       = 1'b1;
  endtask

  task automatic wait_rsp(inout int cyc);
    while (!bus.rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // called at a negedge with the scheduler idle
  task automatic run_vec(input vec_t v, input string nm);
    int cyc;
    set_req(v.req, v.typ, v.w, v.h);
    #1;
    cyc = 0;
    while (!bus.req_ready[v.req] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " accept"}, bus.req_ready, 64'(1 << v.req));
    chk({nm, " no early rsp"}, bus.rsp_valid, 0);
    @(negedge clk);
    bus.req_valid[v.req] = 1'b0;
    cyc = 1;
    wait_rsp(cyc);
    chk({nm, " latency"}, cyc, v.lat);
    chk({nm, " id"}, bus.rsp_id, v.req);
    chk({nm, " area"}, bus.rsp_area, v.area);
    chk({nm, " err"}, bus.rsp_err, v.err);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({nm, " rsp drop"}, bus.rsp_valid, 0);
  endtask

  task automatic get_grant(output int idx);
    int cyc;
    cyc = 0;
    idx = -1;
    while (bus.req_ready == '0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) idx = i;
    chk("grant onehot", $countones(bus.req_ready), 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int cnt;
    int exp_a[5];
    int exp_b[4];

    bus.req_valid = '0;
    bus.req_type  = '0;
    bus.req_w     = '0;
    bus.req_h     = '0;
    bus.rsp_ready = 1'b0;
`ifdef SHAPE_STATS_EN
    stat_clr = 1'b0;
`endif

    vecs[0] = '{0, 2'b00, 16'd3,    16'd5,    32'd15,         1'b0, 17};
    vecs[1] = '{1, 2'b10, 16'd7,    16'd3,    32'd10,         1'b0, 17};
    vecs[2] = '{2, 2'b01, 16'h0100, 16'hDEAD, 32'h0001_0000,  1'b0, 17};
    vecs[3] = '{3, 2'b00, 16'd0,    16'h1234, 32'd0,          1'b0, 17};
    vecs[4] = '{1, 2'b00, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001,  1'b0, 17};
    vecs[5] = '{2, 2'b11, 16'd5,    16'd5,    32'd0,          1'b1, 1};
    vecs[6] = '{3, 2'b10, 16'd5,    16'd5,    32'd12,         1'b0, 17};
    vecs[7] = '{0, 2'b01, 16'hFFFF, 16'h0000, 32'hFFFE_0001,  1'b0, 17};
    vecs[8] = '{1, 2'b10, 16'hFFFF, 16'hFFFF, 32'h7FFF_0000,  1'b0, 17};

    repeat (2) @(negedge clk);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rsp_id", bus.rsp_id, 0);
    chk("reset rsp_area", bus.rsp_area, 0);
    chk("reset rsp_err", bus.rsp_err, 0);
    chk("reset req_ready", bus.req_ready, 0);
`ifdef SHAPE_STATS_EN
    chk("reset stats", {stat_rect, stat_sqr, stat_tri, stat_err}, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef SHAPE_STATS_EN
    chk("stat_rect", stat_rect, 3);
    chk("stat_sqr", stat_sqr, 2);
    chk("stat_tri", stat_tri, 3);
    chk("stat_err", stat_err, 1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("stat clr", {stat_rect, stat_sqr, stat_tri, stat_err}, 0);
`endif

    // back-pressure: response held 10 cycles while another requester waits
    set_req(1, 2'b00, 16'd6, 16'd7);
    #1;
    cnt = 0;
    while (!bus.req_ready[1] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    set_req(2, 2'b00, 16'd2, 16'd3);
    cnt = 1;
    wait_rsp(cnt);
    chk("bp latency", cnt, 17);
    for (int i = 0; i < 10; i++) begin
      chk("bp hold valid", bus.rsp_valid, 1);
      chk("bp hold area", bus.rsp_area, 42);
      chk("bp hold id", bus.rsp_id, 1);
      chk("bp no ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp rsp drop", bus.rsp_valid, 0);
    chk("bp next accept", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    cnt = 1;
    wait_rsp(cnt);
    chk("bp second id", bus.rsp_id, 2);
    chk("bp second area", bus.rsp_area, 6);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // reset in the middle of a multiply; request from req 1 leaves rr_ptr at 2
    set_req(1, 2'b00, 16'd9, 16'd9);
    #1;
    cnt = 0;
    while (!bus.req_ready[1] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", bus.rsp_valid, 0);
    chk("midrst rsp_id", bus.rsp_id, 0);
    chk("midrst rsp_area", bus.rsp_area, 0);
    chk("midrst rsp_err", bus.rsp_err, 0);
    chk("midrst req_ready", bus.req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("midrst no rsp", cnt, 0);
    set_req(0, 2'b00, 16'd1, 16'd1);
    set_req(2, 2'b00, 16'd2, 16'd2);
    #1;
    chk("midrst rr_ptr zero", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (25) @(negedge clk);

    // round robin with all requesters continuously valid
    exp_a = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 16'(i + 1), 16'd2);
    #1;
    for (int i = 0; i < 5; i++) begin
      get_grant(g);
      chk($sformatf("rr all grant%0d", i), g, exp_a[i]);
    end
    bus.req_valid = '0;
    repeat (25) @(negedge clk);

    // round robin with req 0 dropping out after its first grant
    exp_b = '{1, 2, 3, 1};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b01, 16'(i + 1), 16'd0);
    #1;
    get_grant(g);
    chk("rr drop first", g, 0);
    bus.req_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      get_grant(g);
      chk($sformatf("rr drop grant%0d", i), g, exp_b[i]);
    end
    bus.req_valid = '0;
    repeat (25) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
